control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired control unit that sits directly upstream of the datapath.
- Steps through the fetch and execute T-states. Each cycle it drives the one-hot register-file select lines, the bus-source selects, the register load enables and the ALU operation selects that the datapath consumes.
- Decodes R-format ALU instructions from the IR value that the datapath feeds back to it.
- Replaces hand-sequenced control stimulus. The datapath can then run a fetched program autonomously.

Parameters:
- NREGS, 16: number of general registers; sets the width of the R_in/R_out one-hot vectors.
- OPW, 5: opcode field width, located at IR[31:32-OPW].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- IR  in  32  current instruction register contents from the datapath.
- stop  in  1  request to halt after the current instruction completes.
- run  out  1  high while sequencing; low in RESET and HALT.
- state  out  4  current T-state encoding, for debug.
- R_in  out  NREGS  one-hot general register load enable.
- R_out  out  NREGS  one-hot general register bus drive.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes.
- AND, OR, ADD, SUB, MUL, DIV, SHR, SHRA, SHL, ROR, ROL, NEG, NOT  out  1 each  one-hot ALU operation select.

Behaviour:
- Instruction fields:
  - op = IR[31:27], ra = IR[26:23], rb = IR[22:19], rc = IR[18:15].
  - Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 NEG, 10 NOT, 11 MUL, 12 DIV. Values 13-31 are illegal.
- State machine and encoding: RESET=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, HALT=7.
- Outputs are Moore-style, decoded combinationally from state and IR. Every strobe not listed for a state is 0.
- reset (asynchronous): state=RESET, run=0, all strobes 0. The first rising edge after reset deasserts moves to T0.
- T0: IncPC, PCin, MARin, Read, MDRin.
- T1: MDRout, IRin. IR is valid from T2 onward.
- T2: R_out[rb], Yin.
- T3:
  - Binary ops: R_out[rc], Zin, plus the ALU select for op.
  - NEG/NOT: R_out[rb], Zin, plus the select.
- T4:
  - ADD through NOT: Zlowout, R_in[ra]; next state is T0.
  - MUL/DIV: Zlowout, LOin; next state is T5.
- T5 (MUL/DIV only): Zhighout, HIin; next state is T0.
- Exactly one ALU select is high, and only in T3.
- R_in and R_out each have at most one bit set.
- stop is sampled on the final edge of each instruction (T4→T0, or T5→T0 for MUL/DIV). If stop=1, the next state is HALT instead of T0.
- stop asserted mid-instruction does not abort that instruction. The halt takes effect at its completion.
- HALT is sticky; only reset leaves it.
- reset asserted in any state returns to RESET immediately. An in-flight instruction is abandoned; no partial register write occurs after reset asserts.
- Field indices ≥ NREGS are masked to the low log2(NREGS) bits.
- Total latency: 5 cycles per instruction (T0-T4), 6 cycles for MUL/DIV.

Optional Feature:
- Macro: ILLEGAL_OP_HALT_EN.
- Defined: an illegal opcode seen in T2 asserts no T2 strobes, and the next state is HALT.
- Undefined: an illegal opcode executes as a NOP. T2 asserts no strobes, and the next state is T0, so the instruction takes 3 cycles. stop is honoured on that edge as well.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the state encoding constants RESET through HALT;
  - the opcode constants OP_ADD through OP_DIV;
  - the IR field bit-position constants.
- One natural sub-module: reg_select_decoder. It converts a 4-bit register index plus an enable into an NREGS-wide one-hot vector. It is instantiated twice, for R_in and R_out.

Test Plan:
- SHL R4,R3,R7, IR=0x321B8000 → T2: R_out=0x0008 and Yin. T3: R_out=0x0080, SHL and Zin. T4: Zlowout and R_in=0x0010. Then T0.
- ADD R1,R2,R3, IR=0x00918000 → T3: ADD only, R_out=0x0008. T4: R_in=0x0002. Exactly 5 cycles from T0 to T0.
- MUL rb=5, rc=6, IR=0x582B0000 → T3: MUL, R_out=0x0040. T4: Zlowout and LOin. T5: Zhighout and HIin. No R_in bit set. 6 cycles total.
- Assert stop during T2 of an ADD → the ADD completes with R_in pulsed in T4. Then state=7 and run=0, held for 10 cycles.
- Illegal opcode, IR=0xF8000000 → with ILLEGAL_OP_HALT_EN: HALT after T2. Without it: back to T0 after T2 with no strobes.
- Assert reset during T3 → immediately state=0, all strobes 0, no R_in pulse. Fetch restarts at T0 one edge after reset deasserts.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Purpose: shared encodings for the hardwired control sequencer (T-states, opcodes, IR fields, strobe bundles).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_ctrl_pkg;

    // T-state encoding; values are visible on the debug state port.
    typedef enum logic [3:0] {
        RESET = 4'd0,
        T0    = 4'd1,
        T1    = 4'd2,
        T2    = 4'd3,
        T3    = 4'd4,
        T4    = 4'd5,
        T5    = 4'd6,
        HALT  = 4'd7
    } state_t;

    // R-format opcodes; 13..31 are illegal.
    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHRA = 5'd5;
    localparam logic [4:0] OP_SHL  = 5'd6;
    localparam logic [4:0] OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8;
    localparam logic [4:0] OP_NEG  = 5'd9;
    localparam logic [4:0] OP_NOT  = 5'd10;
    localparam logic [4:0] OP_MUL  = 5'd11;
    localparam logic [4:0] OP_DIV  = 5'd12;

    // IR field positions.
    localparam int IR_OP_MSB = 31;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;
    localparam int IR_REG_W  = 4;

    // Datapath strobes other than the register selects and ALU selects.
    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic inc_pc;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic read;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic hi_in;
        logic lo_in;
    } strobe_t;

    // One-hot ALU operation select.
    typedef struct packed {
        logic sel_add;
        logic sel_sub;
        logic sel_and;
        logic sel_or;
        logic sel_shr;
        logic sel_shra;
        logic sel_shl;
        logic sel_ror;
        logic sel_rol;
        logic sel_neg;
        logic sel_not;
        logic sel_mul;
        logic sel_div;
    } alu_sel_t;

endpackage

// File: rtl/reg_select_decoder.sv
// Purpose: 4-bit register index + enable -> NREGS-wide one-hot select (index masked to log2(NREGS) bits).
// Latency: combinational.
// Backpressure: none.
// Ports: idx (register index), en (select enable), onehot (NREGS-wide, at most one bit set).
module reg_select_decoder #(
    parameter int NREGS = 16
) (
    input  logic [3:0]       idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    // Index bits actually addressable; higher index bits are dropped.
    localparam int         IW   = ($clog2(NREGS) < 4) ? $clog2(NREGS) : 4;
    localparam logic [3:0] MASK = 4'((1 << IW) - 1);

    logic [3:0] idx_m;

    assign idx_m = idx & MASK;

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot[i] = en && (idx_m == 4'(i));
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Purpose: hardwired fetch/execute sequencer driving datapath strobes, register selects and ALU selects from T-state and IR.
// Latency: 5 cycles per instruction (T0-T4), 6 for MUL/DIV, 3 for an illegal opcode NOP.
// Backpressure: none; stop halts at the next instruction boundary. Build option ILLEGAL_OP_HALT_EN halts on illegal opcodes.
// Ports: clk, reset (async active-high), IR (instruction from datapath), stop (halt request);
//        run, state (debug), R_in/R_out (one-hot register selects), datapath strobes, one-hot ALU selects.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      IR,
    input  logic             stop,
    output logic             run,
    output logic [3:0]       state,
    output logic [NREGS-1:0] R_in,
    output logic [NREGS-1:0] R_out,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             HIin,
    output logic             LOin,
    output logic             AND,
    output logic             OR,
    output logic             ADD,
    output logic             SUB,
    output logic             MUL,
    output logic             DIV,
    output logic             SHR,
    output logic             SHRA,
    output logic             SHL,
    output logic             ROR,
    output logic             ROL,
    output logic             NEG,
    output logic             NOT
);

    // Opcode compared at least 5 bits wide so the 5-bit opcode constants fit.
    localparam int OPX = (OPW > 5) ? OPW : 5;

    state_t        state_q;
    state_t        state_nxt;
    state_t        end_nxt;
    strobe_t       strb;
    alu_sel_t      alu;
    logic [OPX-1:0] op_x;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic [3:0]    rc;
    logic [3:0]    rout_idx;
    logic          rin_en;
    logic          rout_en;
    logic          op_legal;
    logic          op_unary;
    logic          op_muldiv;
    logic          unused_ir;

    assign op_x = OPX'(IR[IR_OP_MSB -: OPW]);
    assign ra   = IR[IR_RA_LSB +: IR_REG_W];
    assign rb   = IR[IR_RB_LSB +: IR_REG_W];
    assign rc   = IR[IR_RC_LSB +: IR_REG_W];

    // Immediate/unused R-format bits.
    assign unused_ir = ^IR[IR_RC_LSB-1:0];

    assign op_legal  = (op_x <= OPX'(OP_DIV));
    assign op_unary  = (op_x == OPX'(OP_NEG)) || (op_x == OPX'(OP_NOT));
    assign op_muldiv = (op_x == OPX'(OP_MUL)) || (op_x == OPX'(OP_DIV));

    // Last edge of every instruction: stop turns the return to fetch into a halt.
    assign end_nxt = stop ? HALT : T0;

    function automatic alu_sel_t alu_decode(input logic [OPX-1:0] op);
        alu_sel_t s;
        s = '0;
        case (op)
            OPX'(OP_ADD):  s.sel_add  = 1'b1;
            OPX'(OP_SUB):  s.sel_sub  = 1'b1;
            OPX'(OP_AND):  s.sel_and  = 1'b1;
            OPX'(OP_OR):   s.sel_or   = 1'b1;
            OPX'(OP_SHR):  s.sel_shr  = 1'b1;
            OPX'(OP_SHRA): s.sel_shra = 1'b1;
            OPX'(OP_SHL):  s.sel_shl  = 1'b1;
            OPX'(OP_ROR):  s.sel_ror  = 1'b1;
            OPX'(OP_ROL):  s.sel_rol  = 1'b1;
            OPX'(OP_NEG):  s.sel_neg  = 1'b1;
            OPX'(OP_NOT):  s.sel_not  = 1'b1;
            OPX'(OP_MUL):  s.sel_mul  = 1'b1;
            OPX'(OP_DIV):  s.sel_div  = 1'b1;
            default:       s = '0;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RESET;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        strb      = '0;
        alu       = '0;
        rin_en    = 1'b0;
        rout_en   = 1'b0;
        rout_idx  = rb;
        case (state_q)
            RESET: begin
                state_nxt = T0;
            end
            T0: begin
                strb.inc_pc = 1'b1;
                strb.pc_in  = 1'b1;
                strb.mar_in = 1'b1;
                strb.read   = 1'b1;
                strb.mdr_in = 1'b1;
                state_nxt   = T1;
            end
            T1: begin
                strb.mdr_out = 1'b1;
                strb.ir_in   = 1'b1;
                state_nxt    = T2;
            end
            T2: begin
                if (op_legal) begin
                    rout_en   = 1'b1;
                    rout_idx  = rb;
                    strb.y_in = 1'b1;
                    state_nxt = T3;
                end else begin
`ifdef ILLEGAL_OP_HALT_EN
                    state_nxt = HALT;
`else
                    // Illegal opcode retires as a NOP at this edge.
                    state_nxt = end_nxt;
`endif
                end
            end
            T3: begin
                rout_en   = 1'b1;
                rout_idx  = op_unary ? rb : rc;
                strb.z_in = 1'b1;
                alu       = alu_decode(op_x);
                state_nxt = T4;
            end
            T4: begin
                strb.zlow_out = 1'b1;
                if (op_muldiv) begin
                    // Low half of the product/quotient goes to LO; no GPR write.
                    strb.lo_in = 1'b1;
                    state_nxt  = T5;
                end else begin
                    rin_en    = 1'b1;
                    state_nxt = end_nxt;
                end
            end
            T5: begin
                strb.zhigh_out = 1'b1;
                strb.hi_in     = 1'b1;
                state_nxt      = end_nxt;
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = RESET;
            end
        endcase
    end

    reg_select_decoder #(.NREGS(NREGS)) u_rin_dec (
        .idx    (ra),
        .en     (rin_en),
        .onehot (R_in)
    );

    reg_select_decoder #(.NREGS(NREGS)) u_rout_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (R_out)
    );

    assign run   = (state_q != RESET) && (state_q != HALT);
    assign state = state_q;

    assign PCout    = strb.pc_out;
    assign PCin     = strb.pc_in;
    assign IncPC    = strb.inc_pc;
    assign MARin    = strb.mar_in;
    assign MDRin    = strb.mdr_in;
    assign MDRout   = strb.mdr_out;
    assign Read     = strb.read;
    assign IRin     = strb.ir_in;
    assign Yin      = strb.y_in;
    assign Zin      = strb.z_in;
    assign Zlowout  = strb.zlow_out;
    assign Zhighout = strb.zhigh_out;
    assign HIin     = strb.hi_in;
    assign LOin     = strb.lo_in;

    assign ADD  = alu.sel_add;
    assign SUB  = alu.sel_sub;
    assign AND  = alu.sel_and;
    assign OR   = alu.sel_or;
    assign SHR  = alu.sel_shr;
    assign SHRA = alu.sel_shra;
    assign SHL  = alu.sel_shl;
    assign ROR  = alu.sel_ror;
    assign ROL  = alu.sel_rol;
    assign NEG  = alu.sel_neg;
    assign NOT  = alu.sel_not;
    assign MUL  = alu.sel_mul;
    assign DIV  = alu.sel_div;

endmodule

// File: tb/tb_control_sequencer.sv
// Purpose: scoreboard bench for control_sequencer; per-cycle expected outputs queued per instruction, compared each cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stop;
    logic [31:0] IR;

    logic        run;
    logic [3:0]  state;
    logic [15:0] R_in;
    logic [15:0] R_out;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin;
    logic Zlowout, Zhighout, HIin, LOin;
    logic s_and, s_or, s_add, s_sub, s_mul, s_div, s_shr, s_shra, s_shl;
    logic s_ror, s_rol, s_neg, s_not;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .IR       (IR),
        .stop     (stop),
        .run      (run),
        .state    (state),
        .R_in     (R_in),
        .R_out    (R_out),
        .PCout    (PCout),
        .PCin     (PCin),
        .IncPC    (IncPC),
        .MARin    (MARin),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .Read     (Read),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .HIin     (HIin),
        .LOin     (LOin),
        .AND      (s_and),
        .OR       (s_or),
        .ADD      (s_add),
        .SUB      (s_sub),
        .MUL      (s_mul),
        .DIV      (s_div),
        .SHR      (s_shr),
        .SHRA     (s_shra),
        .SHL      (s_shl),
        .ROR      (s_ror),
        .ROL      (s_rol),
        .NEG      (s_neg),
        .NOT      (s_not)
    );

    // Strobe bit positions in the bench's packed strobe vector.
    localparam int B_PCOUT = 13, B_PCIN = 12, B_INCPC = 11, B_MARIN = 10, B_MDRIN = 9;
    localparam int B_MDROUT = 8, B_READ = 7, B_IRIN = 6, B_YIN = 5, B_ZIN = 4;
    localparam int B_ZLOW = 3, B_ZHIGH = 2, B_HIIN = 1, B_LOIN = 0;

    localparam logic [31:0] IR_SHL = 32'h321B8000;
    localparam logic [31:0] IR_ADD = 32'h00918000;
    localparam logic [31:0] IR_MUL = 32'h582B0000;
    localparam logic [31:0] IR_ILL = 32'hF8000000;

    typedef struct packed {
        logic [31:0] ir;
        logic        stp;
        logic [3:0]  st;
        logic        run;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [13:0] strb;
        logic [12:0] alu;
    } rec_t;

    rec_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [13:0] got_strb;
    logic [12:0] got_alu;

    assign got_strb = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin,
                       Zlowout, Zhighout, HIin, LOin};
    // Bit i is the select for opcode i.
    assign got_alu  = {s_div, s_mul, s_not, s_neg, s_rol, s_ror, s_shl, s_shra, s_shr,
                       s_or, s_and, s_sub, s_add};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] ir, input logic stp, input logic [3:0] st,
                                input logic rn);
        rec_t r;
        r      = '0;
        r.ir   = ir;
        r.stp  = stp;
        r.st   = st;
        r.run  = rn;
        return r;
    endfunction

    task automatic compare_rec(input rec_t r);
        check_vec("state",   32'(state),    32'(r.st));
        check_vec("run",     32'(run),      32'(r.run));
        check_vec("R_in",    32'(R_in),     32'(r.rin));
        check_vec("R_out",   32'(R_out),    32'(r.rout));
        check_vec("strobes", 32'(got_strb), 32'(r.strb));
        check_vec("alu_sel", 32'(got_alu),  32'(r.alu));
    endtask

    // Queue the expected per-cycle outputs of one instruction, T0 onward.
    task automatic push_instr(input logic [31:0] ir, input logic stp);
        logic [4:0] op;
        logic [3:0] ra, rb, rc;
        rec_t r;
        op = ir[31:27];
        ra = ir[26:23];
        rb = ir[22:19];
        rc = ir[18:15];

        r = mk(ir, 1'b0, 4'd1, 1'b1);
        r.strb[B_INCPC] = 1'b1; r.strb[B_PCIN] = 1'b1; r.strb[B_MARIN] = 1'b1;
        r.strb[B_READ]  = 1'b1; r.strb[B_MDRIN] = 1'b1;
        q.push_back(r);

        r = mk(ir, 1'b0, 4'd2, 1'b1);
        r.strb[B_MDROUT] = 1'b1; r.strb[B_IRIN] = 1'b1;
        q.push_back(r);

        r = mk(ir, stp, 4'd3, 1'b1);
        if (op <= 5'd12) begin
            r.rout = 16'h1 << rb;
            r.strb[B_YIN] = 1'b1;
        end
        q.push_back(r);
        if (op > 5'd12) return;

        r = mk(ir, stp, 4'd4, 1'b1);
        r.rout = (op == 5'd9 || op == 5'd10) ? (16'h1 << rb) : (16'h1 << rc);
        r.strb[B_ZIN] = 1'b1;
        r.alu = 13'h1 << op;
        q.push_back(r);

        r = mk(ir, stp, 4'd5, 1'b1);
        r.strb[B_ZLOW] = 1'b1;
        if (op == 5'd11 || op == 5'd12) r.strb[B_LOIN] = 1'b1;
        else                            r.rin = 16'h1 << ra;
        q.push_back(r);

        if (op == 5'd11 || op == 5'd12) begin
            r = mk(ir, stp, 4'd6, 1'b1);
            r.strb[B_ZHIGH] = 1'b1; r.strb[B_HIIN] = 1'b1;
            q.push_back(r);
        end
    endtask

    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++) q.push_back(mk(32'h0, 1'b0, 4'd7, 1'b0));
    endtask

    // One queued record per cycle: drive its IR/stop just after the falling edge, then compare.
    task automatic drain();
        rec_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            IR   = r.ir;
            stop = r.stp;
            #1;
            compare_rec(r);
        end
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic apply_reset();
        reset = 1'b1;
        stop  = 1'b0;
        #1;
        compare_rec(mk(32'h0, 1'b0, 4'd0, 1'b0));
        @(negedge clk);
        #1;
        compare_rec(mk(32'h0, 1'b0, 4'd0, 1'b0));
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rir;
        reset = 1'b1;
        stop  = 1'b0;
        IR    = 32'h0;
        @(negedge clk);
        apply_reset();

        push_instr(IR_SHL, 1'b0);
        push_instr(IR_ADD, 1'b0);
        push_instr(IR_MUL, 1'b0);
        drain();

        for (int i = 0; i < 8; i++) begin
            rir = {5'($urandom_range(0, 12)), 4'($urandom), 4'($urandom), 4'($urandom),
                   15'($urandom)};
            push_instr(rir, 1'b0);
        end
        drain();

        push_instr(IR_ILL, 1'b0);
`ifdef ILLEGAL_OP_HALT_EN
        push_halt(3);
        drain();
        apply_reset();
`else
        push_instr(IR_ADD, 1'b0);
        push_instr(IR_ILL, 1'b1);
        push_halt(3);
        drain();
        apply_reset();
`endif

        push_instr(IR_ADD, 1'b1);
        push_halt(10);
        drain();
        apply_reset();

        push_instr(IR_MUL, 1'b1);
        push_halt(2);
        drain();
        apply_reset();

        // Reset mid-instruction: stop after the T3 compare, reset, then refetch.
        push_instr(IR_ADD, 1'b0);
        while (q.size() > 4) void'(q.pop_back());
        drain();
        apply_reset();
        push_instr(IR_SHL, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
